// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, instruction field split, next-PC selection
// and the hardware return-address stack (jal pushes, js pops).
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned RAS_DEPTH = 8,
    parameter int unsigned RAS_PTR_W = 3
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 stall,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_rdata,
    output logic [5:0]           opcode,
    output logic [5:0]           funct,
    output logic [31:0]          instr,
    output logic [31:0]          pc_plus4,
    input  logic [1:0]           Jump,
    input  logic                 Branch,
    input  logic                 branch_taken,
    input  logic                 halt,
    output logic                 halted,
    output logic                 ras_overflow,
    output logic                 ras_underflow,
    output logic [RAS_PTR_W:0]   ras_count
);

    typedef enum logic {
        RUN,
        HALTED
    } state_e;

    localparam logic [5:0]         OP_JAL   = 6'b000011;
    localparam logic [RAS_PTR_W:0] CNT_ONE  = (RAS_PTR_W+1)'(1);
    localparam logic [RAS_PTR_W:0] CNT_FULL = (RAS_PTR_W+1)'(RAS_DEPTH);

    state_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [RAS_PTR_W:0]   cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 halted_q;
    logic                 push;
    logic [31:0]          ras_q [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] top_idx;
    logic [31:0]          jump_tgt;
    logic [31:0]          br_tgt;

    assign imem_addr     = pc_q;
    assign instr         = imem_rdata;
    assign opcode        = imem_rdata[31:26];
    assign funct         = imem_rdata[5:0];
    assign pc_plus4      = pc_q + 32'd4;
    assign halted        = halted_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign ras_count     = cnt_q;

    assign top_idx  = RAS_PTR_W'(cnt_q - CNT_ONE);
    assign jump_tgt = {pc_plus4[31:28], imem_rdata[25:0], 2'b00};
    assign br_tgt   = pc_plus4 + {{14{imem_rdata[15]}}, imem_rdata[15:0], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (state_q == RUN && !stall) begin
            // Jump=11 is illegal and handled like halt
            if (halt || Jump == 2'b11) begin
                state_d = HALTED;
            end else if (Jump == 2'b10) begin
                if (cnt_q == '0) begin
                    pc_d    = RESET_PC;
                    unf_d   = 1'b1;
                    state_d = HALTED;
                end else begin
                    pc_d  = ras_q[top_idx];
                    cnt_d = cnt_q - CNT_ONE;
                end
            end else if (Jump == 2'b01) begin
                pc_d = jump_tgt;
                if (opcode == OP_JAL) begin
                    if (cnt_q == CNT_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end else if (Branch && branch_taken) begin
                pc_d = br_tgt;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            halted_q <= (state_d == HALTED);
        end
    end

    // Stack contents need no reset; only the occupancy count is meaningful.
    always_ff @(posedge Clock) begin
        if (push) begin
            ras_q[cnt_q[RAS_PTR_W-1:0]] <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized cycles, checked
// against a queue-based behavioural model of fetch, branch, jump and the RAS.
module tb_fetch_pc_unit;

    logic        Clock;
    logic        Reset;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [1:0]  Jump;
    logic        Branch;
    logic        branch_taken;
    logic        halt;
    logic        halted;
    logic        ras_overflow;
    logic        ras_underflow;
    logic [3:0]  ras_count;

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .RAS_DEPTH(8),
        .RAS_PTR_W(3)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .stall        (stall),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .opcode       (opcode),
        .funct        (funct),
        .instr        (instr),
        .pc_plus4     (pc_plus4),
        .Jump         (Jump),
        .Branch       (Branch),
        .branch_taken (branch_taken),
        .halt         (halt),
        .halted       (halted),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow),
        .ras_count    (ras_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Behavioural model
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_ovf;
    logic        m_unf;
    logic [31:0] m_ras[$];

    localparam logic [31:0] M_RESET_PC = 32'h0000_0000;
    localparam int          M_DEPTH    = 8;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic [1:0] j,
                              input logic br, input logic tk, input logic hl,
                              input logic [31:0] rd);
        logic [31:0] p4;
        int          off;
        if (rst) begin
            m_pc     = M_RESET_PC;
            m_halted = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_ras.delete();
        end else if (!m_halted && !st) begin
            p4 = m_pc + 32'd4;
            if (hl || j == 2'd3) begin
                m_halted = 1'b1;
            end else if (j == 2'd2) begin
                if (m_ras.size() == 0) begin
                    m_pc     = M_RESET_PC;
                    m_unf    = 1'b1;
                    m_halted = 1'b1;
                end else begin
                    m_pc = m_ras.pop_back();
                end
            end else if (j == 2'd1) begin
                if (rd[31:26] == 6'd3) begin
                    if (m_ras.size() == M_DEPTH) m_ovf = 1'b1;
                    else m_ras.push_back(p4);
                end
                m_pc = {p4[31:28], rd[25:0], 2'b00};
            end else if (br && tk) begin
                off  = int'($signed(rd[15:0]));
                m_pc = p4 + 32'(off * 4);
            end else begin
                m_pc = p4;
            end
        end
    endtask

    // One clock: drive inputs, check decode outputs, advance model, check state.
    task automatic step(input logic rst, input logic st, input logic [1:0] j,
                        input logic br, input logic tk, input logic hl,
                        input logic [31:0] rd);
        Reset        = rst;
        stall        = st;
        Jump         = j;
        Branch       = br;
        branch_taken = tk;
        halt         = hl;
        imem_rdata   = rd;
        #1;
        check("opcode", 32'(opcode), 32'(rd[31:26]));
        check("funct", 32'(funct), 32'(rd[5:0]));
        check("instr", instr, rd);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        model_edge(rst, st, j, br, tk, hl, rd);
        @(posedge Clock);
        #1;
        check("imem_addr", imem_addr, m_pc);
        check("halted", 32'(halted), 32'(m_halted));
        check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
        check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
        check("ras_count", 32'(ras_count), 32'(m_ras.size()));
    endtask

    task automatic nop(input logic [31:0] rd);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, rd);
    endtask

    localparam logic [31:0] JAL_40 = {6'b000011, 26'h40};
    localparam logic [31:0] JAL_80 = {6'b000011, 26'h80};
    localparam logic [31:0] J_80   = {6'b000010, 26'h80};

    initial begin
        logic [31:0] rd;
        logic [1:0]  j;
        m_pc = '0; m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        Reset = 1'b1; stall = 1'b0; Jump = 2'd0; Branch = 1'b0;
        branch_taken = 1'b0; halt = 1'b0; imem_rdata = '0;
        @(posedge Clock);
        #1;

        // Reset and sequential fetch
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("reset_pc", imem_addr, 32'h0);
        check("reset_cnt", 32'(ras_count), 32'h0);
        nop(32'h1234_5678); check("seq4", imem_addr, 32'h4);
        nop(32'h0);         check("seq8", imem_addr, 32'h8);
        nop(32'h0);         check("seqC", imem_addr, 32'hC);
        nop(32'h0);         check("seq10", imem_addr, 32'h10);

        // Branch taken / untaken at 0x10
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h1000_FFFE);
        check("br_taken", imem_addr, 32'h0C);
        nop(32'h0);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h1000_FFFE);
        check("br_not_taken", imem_addr, 32'h14);

        // jal at 0x20 then js
        nop(32'h0); nop(32'h0); nop(32'h0);
        check("at20", imem_addr, 32'h20);
        step(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, JAL_40);
        check("jal_pc", imem_addr, 32'h100);
        check("jal_cnt", 32'(ras_count), 32'd1);
        nop(32'h0);
        step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0);
        check("js_pc", imem_addr, 32'h24);
        check("js_cnt", 32'(ras_count), 32'd0);

        // j does not push
        step(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, J_80);
        check("j_cnt", 32'(ras_count), 32'd0);

        // Nine jal: overflow on the ninth, jump still taken
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, JAL_80);
        check("ovf_cnt", 32'(ras_count), 32'd8);
        check("ovf_flag", 32'(ras_overflow), 32'd1);
        check("ovf_pc", imem_addr, 32'h200);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0);
        check("drain_cnt", 32'(ras_count), 32'd0);

        // Pop from empty
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        nop(32'h0);
        step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0);
        check("unf_pc", imem_addr, 32'h0);
        check("unf_flag", 32'(ras_underflow), 32'd1);
        check("unf_halted", 32'(halted), 32'd1);

        // PC wrap: branch from 0 by -2 words, then +4
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0000_FFFE);
        check("wrap_hi", imem_addr, 32'hFFFF_FFFC);
        check("wrap_p4", pc_plus4, 32'h0);
        nop(32'h0);
        check("wrap_0", imem_addr, 32'h0);

        // Halt under stall, then release; halted ignores jumps
        nop(32'h0); nop(32'h0);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("stall_pc", imem_addr, 32'h8);
        check("stall_halted", 32'(halted), 32'd0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("halt_set", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, JAL_80);
        check("halt_frozen", imem_addr, 32'h8);
        check("halt_cnt", 32'(ras_count), 32'd0);

        // Reset mid-halt
        step(1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, JAL_80);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", imem_addr, 32'h0);

        // Illegal Jump=11
        step(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 32'h0);
        check("j11_halt", 32'(halted), 32'd1);
        check("j11_pc", imem_addr, 32'h0);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            rd = $urandom();
            if ($urandom_range(0, 2) == 0) rd[31:26] = 6'b000011;
            case ($urandom_range(0, 9))
                0, 1:    j = 2'd1;
                2, 3:    j = 2'd2;
                4:       j = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'd0;
                default: j = 2'd0;
            endcase
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0), j,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Holds the PC, drives the instruction-memory address, and splits the returned word into opcode/funct/fields for decode.
- Consumes the decoder's Jump/Branch/halt outputs plus the ALU branch condition, and computes the next PC.
- Owns the hardware return-address stack (RAS): jal pushes the return address, js pops it.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 8, number of return-address stack entries (power of two, 2..32).
- RAS_PTR_W, 3, log2(RAS_DEPTH).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  reset Reset, synchronous, active-high.
- stall  in  1  hold PC and RAS this cycle (hazard or memory wait).
- imem_addr  out  32  byte address to instruction memory (= PC).
- imem_rdata  in  32  instruction word; combinational read of imem_addr.
- opcode  out  6  imem_rdata[31:26].
- funct  out  6  imem_rdata[5:0].
- instr  out  32  imem_rdata pass-through.
- pc_plus4  out  32  PC+4, used for the jal link value.
- Jump  in  2  01 = j/jal, 10 = js (pop RAS), 00 = none.
- Branch  in  1  conditional-branch instruction.
- branch_taken  in  1  ALU condition result for the current branch.
- halt  in  1  decoder halt request.
- halted  out  1  fetch stopped.
- ras_overflow  out  1  sticky: push was attempted while the RAS was full.
- ras_underflow  out  1  sticky: pop was attempted while the RAS was empty.
- ras_count  out  RAS_PTR_W+1  current RAS occupancy.

Behaviour:
- Reset (sampled at a rising edge):
  - PC=RESET_PC, state=RUN, ras_count=0.
  - halted=0, ras_overflow=0, ras_underflow=0.
  - RAS contents are don't-care.
  - Reset dominates all other inputs; a reset mid-halt or mid-stall returns to RUN.
- Outputs imem_addr, opcode, funct, instr and pc_plus4 are combinational from PC and imem_rdata, giving zero-latency decode.
- States:
  - RUN: PC updates every non-stalled edge.
  - HALTED: PC, RAS and flags frozen; halted=1; exit only via Reset.
- RUN -> HALTED on an edge with halt=1 and stall=0. The PC stays at the halt instruction.
- The control unit asserts halt for undefined opcodes; this block treats that identically to an explicit halt.
- Next-PC priority, evaluated in RUN with stall=0:
  1. halt -> PC unchanged.
  2. Jump=10 (js) -> PC = RAS top; pop.
  3. Jump=01 -> PC = {pc_plus4[31:28], instr[25:0], 2'b00}. Push pc_plus4 only when opcode==6'b000011 (jal); j does not push.
  4. Branch & branch_taken -> PC = pc_plus4 + (sign-extend(instr[15:0]) << 2), 32-bit wrap.
  5. Otherwise -> PC = pc_plus4.
- Jump=11 is illegal: treat it as halt and enter HALTED.
- RAS:
  - Push writes entry[ras_count] and increments the count.
  - Pop reads entry[ras_count-1] and decrements the count.
  - Push when full (ras_count==RAS_DEPTH): the push is dropped, ras_overflow is set, and the jump is still taken.
  - Pop when empty: PC=RESET_PC, ras_underflow is set, state moves to HALTED on the same edge.
- stall=1 in RUN: PC, RAS, state and flags hold. halt, Jump and Branch are ignored that cycle.
- PC arithmetic is modulo 2^32; PC+4 from 32'hFFFF_FFFC wraps to 0.
- PC[1:0] is always 00 by construction.

Test Plan:
- Sequential fetch: Reset one cycle, RESET_PC=0, then no control inputs -> imem_addr steps 0,4,8,0xC on successive edges. halted=0, ras_count=0.
- Taken and untaken branch at PC=0x10 with instr[15:0]=16'hFFFE:
  - Branch=1, branch_taken=1 -> next PC=0x0C.
  - Branch=1, branch_taken=0 -> next PC=0x14.
- jal then js:
  - At PC=0x20 with opcode=000011, instr[25:0]=26'h40, Jump=01 -> PC=0x100, ras_count=1.
  - Later Jump=10 -> PC=0x24, ras_count=0.
- RAS bounds:
  - 9 consecutive jal with RAS_DEPTH=8 -> ras_count=8, ras_overflow=1 after the 9th, PC still jumps.
  - From empty, js -> PC=RESET_PC, ras_underflow=1, halted=1.
- Halt plus stall:
  - halt=1 with stall=1 -> PC holds, halted=0.
  - Release stall -> halted=1 next edge; PC frozen for 10 cycles despite Jump=01.
- Reset mid-halt: while halted=1, assert Reset -> next edge PC=RESET_PC, halted=0, all flags cleared, ras_count=0.
